indicator_lamp_driver: RTL
==========================

# indicator_lamp_driver

Lamp and dashboard back end for the vehicle controller. Consumes the registered turn-signal and gear state codes produced by the vehicle control FSM and drives physical outputs: flashing left/right indicators, hazard flashing, reverse lamp, one-hot gear display and an audible click pulse. Sits between the control FSM and the body I/O pins. Implements lane-change comfort flashing (minimum flash count) and hazard override.

## Interface

- `BLINK_HALF_PERIOD`, default 50: cycles per lamp on-phase and per off-phase; must be ≥ 2.
- `MIN_FLASHES`, default 3: minimum number of completed on-phases once a turn indication starts; must be ≥ 1.

- `clock`  in  1  single clock; all state updates on its rising edge.
- `_resetN`  in  1  asynchronous, active-low reset.
- `_switch`  in  1  ignition; 0 = off.
- `_hazard`  in  1  hazard request, level; honoured regardless of `_switch`.
- `_turnState`  in  2  00 none, 01 left, 11 right, 10 invalid (treated as none).
- `_gearState`  in  2  00 lock, 01 parking, 10 reverse, 11 forward.
- `_leftLamp`  out  1  left indicator lamp.
- `_rightLamp`  out  1  right indicator lamp.
- `_reverseLamp`  out  1  reverse lamp.
- `_gearDisplay`  out  3  one-hot {F,R,P}; 000 in lock or ignition off.
- `_clickPulse`  out  1  one-cycle pulse coincident with every indicator lamp edge.

## Operation

- All outputs registered. Reset value of every output is 0; FSM in IDLE, counters 0.
- FSM states: IDLE, LEFT, RIGHT, HAZARD. Evaluated each cycle, in priority order:
  - `_hazard`=1 → HAZARD; entering from any other state restarts the timer at on-phase.
  - `_switch`=0 → IDLE immediately; no comfort flashing.
  - Request left (01) → LEFT; request right (11) → RIGHT. A switch between LEFT and RIGHT restarts the timer and flash count in the new direction.
  - Request none, state LEFT/RIGHT: remain until flash count ≥ `MIN_FLASHES` and phase is off, then IDLE. An on-phase is never truncated by a dropped request.
  - HAZARD with `_hazard`=0 → IDLE, or LEFT/RIGHT per the current request (fresh start); no comfort flashing after hazard.
- Blink timer: phase counter 0..`BLINK_HALF_PERIOD`-1, width $clog2(`BLINK_HALF_PERIOD`); at terminal count phase toggles and counter wraps to 0. Flash counter increments at each on→off transition, width $clog2(`MIN_FLASHES`+1), saturates at `MIN_FLASHES`. Both held at 0 in IDLE.
- Lamps: LEFT → `_leftLamp` = phase; RIGHT → `_rightLamp` = phase; HAZARD → both = phase, in unison; IDLE → both 0.
- `_clickPulse` = 1 for exactly the cycle in which either lamp output differs from its previous value; simultaneous edges of both lamps produce a single pulse.
- `_reverseLamp` = `_switch` & (`_gearState` == 10). `_gearDisplay`: parking 001, reverse 010, forward 100, lock 000; forced 000 when `_switch`=0.

## Timing

- Latency: one cycle from input change to output change for every path.
- First on-phase begins in the first cycle the FSM is in LEFT/RIGHT/HAZARD; on-phase and off-phase each last exactly `BLINK_HALF_PERIOD` cycles.
- Flash period = 2×`BLINK_HALF_PERIOD` cycles; no jitter across state re-entry other than the defined restart.
- Comfort exit: lamp goes low at end of the `MIN_FLASHES`-th on-phase; FSM reaches IDLE on the following cycle. Subsequent lamp outputs remain 0.
- `_resetN` assertion mid-flash: outputs 0 immediately (asynchronous); operation resumes on the first clock edge after deassertion.
- Simultaneous `_switch` fall and `_hazard` rise: HAZARD wins.

## Structure

- Shared package `vehicle_pkg`: turn-state and gear-state encodings (common with the control FSM), lamp FSM enum, gear-display one-hot constants.
- Sub-module `blink_timer`: phase counter, phase output, on→off strobe, restart input; parameterised by `BLINK_HALF_PERIOD`. Flash counter and FSM remain in the top.

## Test plan

With `BLINK_HALF_PERIOD`=4, `MIN_FLASHES`=3:
- Hold `_resetN`=0 with all inputs active → all outputs 0; release with `_switch`=1, gear 01 → `_gearDisplay`=001 one cycle later.
- `_turnState`=01 held → `_leftLamp` 1 for 4 cycles, 0 for 4, repeating; `_clickPulse` on every edge; `_rightLamp` stays 0.
- `_turnState`=11 for one cycle then 00 → exactly 3 on-phases (12 lamp-on cycles), then IDLE; no further pulses.
- Left flashing, switch to 11 in 2nd cycle of an on-phase → next cycle `_leftLamp`=0, `_rightLamp`=1, single click pulse, fresh 4-cycle on-phase.
- `_switch`=0, `_hazard`=1 → both lamps flash in unison, `_gearDisplay`=000; drop `_hazard` mid-on-phase → both lamps 0 next cycle.
- Gear 10 with right flashing, drop `_switch` → next cycle `_reverseLamp`=0, `_rightLamp`=0, `_gearDisplay`=000; assert `_resetN`=0 mid-flash → outputs 0 without a clock edge.

Source files
------------

// File: rtl/indicator_lamp_driver_pkg.sv
// Shared vehicle encodings: turn/gear codes from the control FSM, lamp FSM states
// and the one-hot gear display patterns.
package vehicle_pkg;

    typedef enum logic [1:0] {
        TURN_NONE    = 2'b00,
        TURN_LEFT    = 2'b01,
        TURN_INVALID = 2'b10,
        TURN_RIGHT   = 2'b11
    } turn_state_e;

    typedef enum logic [1:0] {
        GEAR_LOCK    = 2'b00,
        GEAR_PARK    = 2'b01,
        GEAR_REVERSE = 2'b10,
        GEAR_FORWARD = 2'b11
    } gear_state_e;

    typedef enum logic [1:0] {
        LAMP_IDLE,
        LAMP_LEFT,
        LAMP_RIGHT,
        LAMP_HAZARD
    } lamp_state_e;

    localparam logic [2:0] GEAR_DISP_NONE    = 3'b000;
    localparam logic [2:0] GEAR_DISP_PARK    = 3'b001;
    localparam logic [2:0] GEAR_DISP_REVERSE = 3'b010;
    localparam logic [2:0] GEAR_DISP_FORWARD = 3'b100;

    function automatic logic [2:0] gear_display(input logic ignition, input gear_state_e gear);
        logic [2:0] disp;
        disp = GEAR_DISP_NONE;
        if (ignition) begin
            case (gear)
                GEAR_PARK:    disp = GEAR_DISP_PARK;
                GEAR_REVERSE: disp = GEAR_DISP_REVERSE;
                GEAR_FORWARD: disp = GEAR_DISP_FORWARD;
                default:      disp = GEAR_DISP_NONE;
            endcase
        end
        return disp;
    endfunction

endpackage

// File: rtl/indicator_lamp_driver_if.sv
// Control-FSM/body-I/O bundle for the lamp driver; master drives requests,
// slave (the driver) returns lamp and dashboard outputs.
interface indicator_lamp_driver_if;

    logic       _switch;
    logic       _hazard;
    logic [1:0] _turnState;
    logic [1:0] _gearState;
    logic       _leftLamp;
    logic       _rightLamp;
    logic       _reverseLamp;
    logic [2:0] _gearDisplay;
    logic       _clickPulse;

    modport master (
        output _switch, _hazard, _turnState, _gearState,
        input  _leftLamp, _rightLamp, _reverseLamp, _gearDisplay, _clickPulse
    );

    modport slave (
        input  _switch, _hazard, _turnState, _gearState,
        output _leftLamp, _rightLamp, _reverseLamp, _gearDisplay, _clickPulse
    );

endinterface

// File: rtl/indicator_lamp_driver_blink_timer.sv
// Half-period blink timer: on/off phase with restart-to-on and an on->off strobe.
// o_phase_next exposes the value the phase register takes at the coming edge.
module blink_timer #(
    parameter int unsigned BLINK_HALF_PERIOD = 50
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_enable,
    input  logic i_restart,
    output logic o_phase,
    output logic o_phase_next,
    output logic o_off_strobe
);

    localparam int unsigned    CW   = (BLINK_HALF_PERIOD > 1) ? $clog2(BLINK_HALF_PERIOD) : 1;
    localparam logic [CW-1:0]  TERM = CW'(BLINK_HALF_PERIOD - 1);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic          r_phase;
    logic          w_phase_next;
    logic          w_terminal;

    always_comb begin
        w_terminal   = (r_cnt == TERM);
        w_cnt_next   = '0;
        w_phase_next = 1'b0;
        if (i_enable && i_restart) begin
            w_phase_next = 1'b1;
        end else if (i_enable) begin
            if (w_terminal) begin
                w_phase_next = ~r_phase;
            end else begin
                w_cnt_next   = r_cnt + CW'(1);
                w_phase_next = r_phase;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_next;
            r_phase <= w_phase_next;
        end
    end

    assign o_phase      = r_phase;
    assign o_phase_next = w_phase_next;
    assign o_off_strobe = i_enable & ~i_restart & w_terminal & r_phase;

endmodule

// File: rtl/indicator_lamp_driver.sv
// Lamp/dashboard back end: turn, hazard and comfort flashing FSM, click pulse,
// reverse lamp and one-hot gear display, all outputs registered.
module indicator_lamp_driver
    import vehicle_pkg::*;
#(
    parameter int unsigned BLINK_HALF_PERIOD = 50,
    parameter int unsigned MIN_FLASHES       = 3
) (
    input  logic                    clock,
    input  logic                    _resetN,
    indicator_lamp_driver_if.slave  bus
);

    localparam int unsigned   FW        = $clog2(MIN_FLASHES + 1);
    localparam logic [FW-1:0] FLASH_MAX = FW'(MIN_FLASHES);

    lamp_state_e   r_state;
    lamp_state_e   w_next_state;
    turn_state_e   w_turn;
    logic [FW-1:0] r_flash;
    logic          w_restart;
    logic          w_enable;
    logic          w_phase;
    logic          w_phase_next;
    logic          w_off_strobe;
    logic          w_left_next;
    logic          w_right_next;
    logic          r_left;
    logic          r_right;
    logic          r_click;
    logic          r_reverse;
    logic [2:0]    r_gear_disp;

    assign w_turn = turn_state_e'(bus._turnState);

    always_comb begin
        w_next_state = LAMP_IDLE;
        if (bus._hazard) begin
            w_next_state = LAMP_HAZARD;
        end else if (!bus._switch) begin
            w_next_state = LAMP_IDLE;
        end else if (w_turn == TURN_LEFT) begin
            w_next_state = LAMP_LEFT;
        end else if (w_turn == TURN_RIGHT) begin
            w_next_state = LAMP_RIGHT;
        end else if ((r_state == LAMP_LEFT || r_state == LAMP_RIGHT) &&
                     !(r_flash >= FLASH_MAX && !w_phase)) begin
            // Comfort flashing: hold direction until enough flashes and the lamp is off
            w_next_state = r_state;
        end
    end

    // Any change into an active state starts a fresh on-phase and flash count
    assign w_enable  = (w_next_state != LAMP_IDLE);
    assign w_restart = w_enable && (w_next_state != r_state);

    blink_timer #(
        .BLINK_HALF_PERIOD(BLINK_HALF_PERIOD)
    ) u_blink_timer (
        .i_clk        (clock),
        .i_rst_n      (_resetN),
        .i_enable     (w_enable),
        .i_restart    (w_restart),
        .o_phase      (w_phase),
        .o_phase_next (w_phase_next),
        .o_off_strobe (w_off_strobe)
    );

    assign w_left_next  = w_phase_next && (w_next_state == LAMP_LEFT  || w_next_state == LAMP_HAZARD);
    assign w_right_next = w_phase_next && (w_next_state == LAMP_RIGHT || w_next_state == LAMP_HAZARD);

    always_ff @(posedge clock or negedge _resetN) begin
        if (!_resetN) begin
            r_state     <= LAMP_IDLE;
            r_flash     <= '0;
            r_left      <= 1'b0;
            r_right     <= 1'b0;
            r_click     <= 1'b0;
            r_reverse   <= 1'b0;
            r_gear_disp <= GEAR_DISP_NONE;
        end else begin
            r_state <= w_next_state;
            if (!w_enable || w_restart) begin
                r_flash <= '0;
            end else if (w_off_strobe && r_flash != FLASH_MAX) begin
                r_flash <= r_flash + FW'(1);
            end
            r_left      <= w_left_next;
            r_right     <= w_right_next;
            r_click     <= (w_left_next != r_left) || (w_right_next != r_right);
            r_reverse   <= bus._switch && (gear_state_e'(bus._gearState) == GEAR_REVERSE);
            r_gear_disp <= gear_display(bus._switch, gear_state_e'(bus._gearState));
        end
    end

    assign bus._leftLamp    = r_left;
    assign bus._rightLamp   = r_right;
    assign bus._reverseLamp = r_reverse;
    assign bus._gearDisplay = r_gear_disp;
    assign bus._clickPulse  = r_click;

endmodule
